// File: rtl/channel_protocol_monitor.sv
// channel_protocol_monitor
//   Watches NCH independent valid/ready channels for protocol violations:
//   - drop:    a stalled channel lowers valid on the next cycle
//   - change:  a stalled channel alters its payload on the next cycle
//   - timeout: a channel stays stalled for TIMEOUT consecutive cycles
//              (present only when CHANNEL_MON_TIMEOUT_EN is defined)
//   Errors are reported one cycle after detection through a pulse, sticky
//   per-channel flags, a saturating cycle counter, and first-error capture.
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   ch_valid, ch_ready    per-channel handshake (NCH bits each)
//   ch_bits               per-channel payload, channel i at [i*W +: W]
//   err_clear             synchronous clear of all error reporting state
//   err_pulse             one-cycle pulse per cycle with new error(s)
//   err_sticky            channel i at [3i +: 3] = {timeout, change, drop}
//   err_count             saturating count of error cycles
//   first_ch, first_code  first error since reset/clear (code 1/2/3, 0 none)
module channel_protocol_monitor #(
  parameter int NCH     = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NCH-1:0]                       ch_valid,
  input  logic [NCH-1:0]                       ch_ready,
  input  logic [NCH*W-1:0]                     ch_bits,
  input  logic                                 err_clear,
  output logic                                 err_pulse,
  output logic [3*NCH-1:0]                     err_sticky,
  output logic [CW-1:0]                        err_count,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_ch,
  output logic [1:0]                           first_code
);

  localparam int FW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   r_stall;
  logic [NCH*W-1:0] r_bits;

  logic [NCH-1:0]   w_stall;
  logic [NCH-1:0]   w_drop;
  logic [NCH-1:0]   w_chg;
  logic [NCH-1:0]   w_tmo;
  logic [3*NCH-1:0] w_new;
  logic             w_any;
  logic [FW-1:0]    w_fch;
  logic [1:0]       w_fcode;
  logic             w_found;

  assign w_stall = ch_valid & ~ch_ready;

`ifdef CHANNEL_MON_TIMEOUT_EN
  logic [NCH-1:0][7:0] r_cnt;

  // Timeout fires on the stalled cycle that moves the counter to TIMEOUT;
  // once saturated the counter no longer sits at TIMEOUT-1, so it cannot repeat.
  always_comb begin
    w_tmo = '0;
    for (int unsigned i = 0; i < NCH; i++)
      w_tmo[i] = w_stall[i] && (r_cnt[i] == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!w_stall[i])
          r_cnt[i] <= '0;
        else if (r_cnt[i] != 8'(TIMEOUT))
          r_cnt[i] <= r_cnt[i] + 8'd1;
      end
    end
  end
`else
  assign w_tmo = '0;
`endif

  always_comb begin
    w_drop  = '0;
    w_chg   = '0;
    w_new   = '0;
    w_fch   = '0;
    w_fcode = 2'd0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_drop[i] = r_stall[i] && !ch_valid[i];
      w_chg[i]  = r_stall[i] && ch_valid[i] &&
                  (ch_bits[i*W +: W] != r_bits[i*W +: W]);
      w_new[3*i +: 3] = {w_tmo[i], w_chg[i], w_drop[i]};
      // Ascending scan with a found flag: lowest channel index wins.
      if (!w_found && (w_drop[i] || w_chg[i] || w_tmo[i])) begin
        w_found = 1'b1;
        w_fch   = FW'(i);
        w_fcode = w_drop[i] ? 2'd1 : (w_chg[i] ? 2'd2 : 2'd3);
      end
    end
  end

  assign w_any = |w_new;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall    <= '0;
      r_bits     <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= '0;
      err_count  <= '0;
      first_ch   <= '0;
      first_code <= 2'd0;
    end else begin
      r_stall <= w_stall;
      r_bits  <= ch_bits;
      if (err_clear) begin
        err_pulse  <= 1'b0;
        err_sticky <= '0;
        err_count  <= '0;
        first_ch   <= '0;
        first_code <= 2'd0;
      end else begin
        err_pulse  <= w_any;
        err_sticky <= err_sticky | w_new;
        if (w_any && (err_count != '1))
          err_count <= err_count + 1'b1;
        if (w_any && (first_code == 2'd0)) begin
          first_ch   <= w_fch;
          first_code <= w_fcode;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_protocol_monitor.sv
module tb_channel_protocol_monitor;

  localparam int NCH     = 2;
  localparam int W       = 8;
  localparam int TIMEOUT = 4;
  localparam int CW      = 8;
  localparam int FW      = 1;
  localparam int BW      = 1 + 3*NCH + CW + FW + 2;
`ifdef CHANNEL_MON_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   ch_valid = '0;
  logic [NCH-1:0]   ch_ready = '0;
  logic [NCH*W-1:0] ch_bits = '0;
  logic             err_clear = 1'b0;
  logic             err_pulse;
  logic [3*NCH-1:0] err_sticky;
  logic [CW-1:0]    err_count;
  logic [FW-1:0]    first_ch;
  logic [1:0]       first_code;

  channel_protocol_monitor #(.NCH(NCH), .W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock(clk), .reset_n(rst_n), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_bits(ch_bits), .err_clear(err_clear), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_count(err_count), .first_ch(first_ch),
    .first_code(first_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];

  // Reference model state: previous-cycle view of each channel and the
  // length of the current uninterrupted stall run (unbounded integer).
  bit       m_prev_stall[NCH];
  int       m_prev_bits[NCH];
  int       m_run[NCH];
  bit [2:0] m_sticky[NCH];
  int       m_count;
  int       m_fch;
  int       m_fcode;

  function automatic logic [BW-1:0] dut_bundle();
    return {err_pulse, err_sticky, err_count, first_ch, first_code};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_prev_stall[i] = 0; m_prev_bits[i] = 0; m_run[i] = 0; m_sticky[i] = '0;
    end
    m_count = 0; m_fch = 0; m_fcode = 0;
  endtask

  // Drive one cycle of stimulus at the falling edge and push the outputs
  // expected after the following rising edge.
  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] r,
                      input logic [NCH*W-1:0] b, input logic clr);
    bit drop, chg, tmo, stalled, any, pulse;
    int val;
    logic [3*NCH-1:0] stk;
    @(negedge clk);
    ch_valid = v; ch_ready = r; ch_bits = b; err_clear = clr;
    any = 0;
    for (int i = 0; i < NCH; i++) begin
      val     = int'(b[i*W +: W]);
      stalled = v[i] && !r[i];
      drop    = m_prev_stall[i] && !v[i];
      chg     = m_prev_stall[i] && v[i] && (val != m_prev_bits[i]);
      m_run[i] = stalled ? m_run[i] + 1 : 0;
      tmo     = TMO_EN && stalled && (m_run[i] == TIMEOUT);
      if ((drop || chg || tmo) && !clr) begin
        if (!any && m_fcode == 0) begin
          m_fch   = i;
          m_fcode = drop ? 1 : (chg ? 2 : 3);
        end
        m_sticky[i] = m_sticky[i] | {tmo, chg, drop};
      end
      any = any || drop || chg || tmo;
      m_prev_stall[i] = stalled;
      m_prev_bits[i]  = val;
    end
    if (clr) begin
      pulse = 0;
      for (int i = 0; i < NCH; i++) m_sticky[i] = '0;
      m_count = 0; m_fch = 0; m_fcode = 0;
    end else begin
      pulse = any;
      if (any && m_count < (1 << CW) - 1) m_count++;
    end
    for (int i = 0; i < NCH; i++) stk[3*i +: 3] = m_sticky[i];
    exp_q.push_back({pulse, stk, CW'(m_count), FW'(m_fch), 2'(m_fcode)});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0);
  endtask

  // Monitor: compare every registered output set against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) chk("scoreboard", 64'(dut_bundle()), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [NCH*W-1:0] b;
  logic [NCH-1:0]   rv, rr;

  initial begin
    model_reset();
    #1;
    chk("reset_state", 64'(dut_bundle()), 64'(0));
    #22 rst_n = 1'b1;

    // Stall then accept: legal.
    step(2'b01, 2'b00, 16'h005A, 0);
    step(2'b01, 2'b00, 16'h005A, 0);
    step(2'b01, 2'b01, 16'h005A, 0);
    idle(2);
    chk("legal_count", 64'(err_count), 64'(0));

    // Payload change while stalled.
    step(2'b01, 2'b00, 16'h005A, 0);
    step(2'b01, 2'b01, 16'h005B, 0);
    @(posedge clk); #2;
    chk("chg_pulse", 64'(err_pulse), 64'(1));
    chk("chg_sticky", 64'(err_sticky), 64'(6'b000010));
    chk("chg_first", 64'({first_ch, first_code}), 64'({1'b0, 2'd2}));
    chk("chg_count", 64'(err_count), 64'(1));
    idle(1);
    step('0, '0, '0, 1);

    // Ch1 long stall: one timeout only.
    for (int k = 0; k < 6; k++) step(2'b10, 2'b00, 16'h3300, 0);
    step(2'b10, 2'b10, 16'h3300, 0);
    idle(1);
    chk("tmo_sticky", 64'(err_sticky), TMO_EN ? 64'(6'b100000) : 64'(0));
    chk("tmo_count", 64'(err_count), TMO_EN ? 64'(1) : 64'(0));
    step('0, '0, '0, 1);

    // Simultaneous drop on ch1 and change on ch0.
    step(2'b11, 2'b00, 16'h115A, 0);
    step(2'b01, 2'b01, 16'h115B, 0);
    @(posedge clk); #2;
    chk("multi_sticky", 64'(err_sticky), 64'(6'b001010));
    chk("multi_count", 64'(err_count), 64'(1));
    chk("multi_first", 64'({first_ch, first_code}), 64'({1'b0, 2'd2}));
    step('0, '0, '0, 1);

    // 300 consecutive error cycles: changing payload under a held stall.
    for (int k = 0; k < 301; k++) step(2'b01, 2'b00, 16'(k & 8'hFF), 0);
    @(posedge clk); #2;
    chk("sat_count", 64'(err_count), 64'(255));
    step(2'b01, 2'b00, 16'h00AA, 1);
    @(posedge clk); #2;
    chk("clear_wins", 64'(dut_bundle()), 64'(0));
    idle(2);

    // Reset mid-stall, then valid drops right after release.
    step(2'b01, 2'b00, 16'h0042, 0);
    step(2'b01, 2'b00, 16'h0042, 0);
    @(posedge clk); #2;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'(dut_bundle()), 64'(0));
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    step('0, '0, '0, 0);
    idle(2);
    chk("no_drop_after_reset", 64'(err_sticky), 64'(0));

    // Randomized traffic with small payload alphabet and occasional clears.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NCH; i++) begin
        rv[i] = ($urandom_range(0, 9) < 7);
        rr[i] = ($urandom_range(0, 9) < 4);
        b[i*W +: W] = W'($urandom_range(0, 2));
      end
      step(rv, rr, b, $urandom_range(0, 49) == 0);
    end
    idle(3);
    @(posedge clk); #3;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
